// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg: widths and opcode encodings shared by the accumulator core
package cpu_core_pkg;
    localparam int OPC_W  = 4;
    localparam int IMM_W  = 4;
    localparam int DATA_W = 8;
    localparam int PC_W   = 8;
    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUBI = 4'h3;
    localparam logic [OPC_W-1:0] OP_ANDI = 4'h4;
    localparam logic [OPC_W-1:0] OP_ORI  = 4'h5;
    localparam logic [OPC_W-1:0] OP_XORI = 4'h6;
    localparam logic [OPC_W-1:0] OP_SHL  = 4'h7;
    localparam logic [OPC_W-1:0] OP_SHR  = 4'h8;
    localparam logic [OPC_W-1:0] OP_LDH  = 4'h9;
    localparam logic [OPC_W-1:0] OP_NOT  = 4'hA;
    localparam logic [OPC_W-1:0] OP_JR   = 4'hB;
    localparam logic [OPC_W-1:0] OP_BZ   = 4'hC;
    localparam logic [OPC_W-1:0] OP_BNZ  = 4'hD;
    localparam logic [OPC_W-1:0] OP_JMPA = 4'hE;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;
endpackage

// File: rtl/cpu_core_alu.sv
// cpu_core_alu: combinational next-accumulator computation
module cpu_core_alu
    import cpu_core_pkg::*;
(
    input  logic [OPC_W-1:0]  op,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] nacc
);
    logic [DATA_W-1:0] zimm;
    assign zimm = {4'h0, imm};
    always_comb begin
        nacc = acc;
        case (op)
            OP_LDI:  nacc = zimm;
            OP_ADDI: nacc = acc + zimm;
            OP_SUBI: nacc = acc - zimm;
            OP_ANDI: nacc = acc & zimm;
            OP_ORI:  nacc = acc | zimm;
            OP_XORI: nacc = acc ^ zimm;
            OP_SHL:  nacc = acc << imm[2:0];
            OP_SHR:  nacc = acc >> imm[2:0];
            OP_LDH:  nacc = {imm, acc[3:0]};
            OP_NOT:  nacc = ~acc;
            default: nacc = acc;
        endcase
    end
endmodule

// File: rtl/cpu_core.sv
// cpu_core: single-cycle 8-bit accumulator CPU; CPU_CORE_HALT_EN makes opcode F a sticky halt
module cpu_core
    import cpu_core_pkg::*;
(
    input  logic              clk,
    input  logic              CLB,
    input  logic [7:0]        input_ins,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] accum_value
);
    logic [OPC_W-1:0]  op;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] nacc;
    logic [PC_W-1:0]   rel;
    logic [PC_W-1:0]   npc;
    logic              z;
    assign op  = input_ins[7:4];
    assign imm = input_ins[3:0];
    assign z   = accum_value == '0;
    assign rel = pc + {{4{imm[3]}}, imm};
    cpu_core_alu u_alu (
        .op   (op),
        .imm  (imm),
        .acc  (accum_value),
        .nacc (nacc)
    );
    always_comb begin
        npc = op == OP_JR              ? rel :
              (op == OP_BZ  &&  z)     ? rel :
              (op == OP_BNZ && !z)     ? rel :
              op == OP_JMPA            ? accum_value :
                                         pc + 8'd1;
    end
`ifdef CPU_CORE_HALT_EN
    logic halted;
    // the halting instruction itself still advances pc; everything after it is ignored
    always_ff @(posedge clk) begin
        if (CLB) begin
            pc          <= '0;
            accum_value <= '0;
            halted      <= 1'b0;
        end else if (!halted) begin
            pc          <= npc;
            accum_value <= nacc;
            halted      <= op == OP_HALT;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (CLB) begin
            pc          <= '0;
            accum_value <= '0;
        end else begin
            pc          <= npc;
            accum_value <= nacc;
        end
    end
`endif
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed vector table, halt sequence and randomized run against a reference model
module tb_cpu_core;
    logic       clk = 1'b0;
    logic       CLB = 1'b1;
    logic [7:0] input_ins = 8'h1F;
    logic [7:0] pc;
    logic [7:0] accum_value;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       clb;
        logic [7:0] ins;
        logic [7:0] pc;
        logic [7:0] acc;
    } vec_t;
    vec_t tbl[$];

    int  m_pc, m_acc;
    bit  m_halt;

    cpu_core dut (
        .clk         (clk),
        .CLB         (CLB),
        .input_ins   (input_ins),
        .pc          (pc),
        .accum_value (accum_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic [7:0] i, input logic [7:0] p, input logic [7:0] a);
        vec_t v;
        v.clb = c; v.ins = i; v.pc = p; v.acc = a;
        tbl.push_back(v);
    endtask

    task automatic step(input logic c, input logic [7:0] i);
        CLB = c;
        input_ins = i;
        @(posedge clk);
        #1;
    endtask

    // reference model: architectural effect of one clock edge, from the instruction-set rules
    task automatic model(input logic c, input logic [7:0] ins);
        int op, imm, s, np;
        op  = ins[7:4];
        imm = ins[3:0];
        s   = imm >= 8 ? imm - 16 : imm;
        if (c) begin
            m_pc = 0; m_acc = 0; m_halt = 0;
            return;
        end
        if (m_halt) return;
        np = m_pc + 1;
        case (op)
            1:  m_acc = imm;
            2:  m_acc = m_acc + imm;
            3:  m_acc = m_acc - imm;
            4:  m_acc = m_acc & imm;
            5:  m_acc = m_acc | imm;
            6:  m_acc = m_acc ^ imm;
            7:  m_acc = m_acc * (1 << (imm % 8));
            8:  m_acc = m_acc / (1 << (imm % 8));
            9:  m_acc = imm * 16 + m_acc % 16;
            10: m_acc = 255 - m_acc;
            11: np = m_pc + s;
            12: if (m_acc == 0) np = m_pc + s;
            13: if (m_acc != 0) np = m_pc + s;
            14: np = m_acc;
`ifdef CPU_CORE_HALT_EN
            15: m_halt = 1;
`endif
            default: ;
        endcase
        m_acc = ((m_acc % 256) + 256) % 256;
        m_pc  = ((np % 256) + 256) % 256;
    endtask

    initial begin
        add(1, 8'h1F, 8'h00, 8'h00);
        add(1, 8'h1F, 8'h00, 8'h00);
        add(0, 8'h1F, 8'h01, 8'h0F);
        add(0, 8'h23, 8'h02, 8'h12);
        add(0, 8'h35, 8'h03, 8'h0D);
        add(0, 8'h10, 8'h04, 8'h00);
        add(0, 8'h31, 8'h05, 8'hFF);
        add(0, 8'h21, 8'h06, 8'h00);
        add(0, 8'h15, 8'h07, 8'h05);
        add(0, 8'h9A, 8'h08, 8'hA5);
        add(0, 8'h71, 8'h09, 8'h4A);
        add(0, 8'h82, 8'h0A, 8'h12);
        add(0, 8'hA0, 8'h0B, 8'hED);
        add(0, 8'h1F, 8'h0C, 8'h0F);
        add(0, 8'hE0, 8'h0F, 8'h0F);
        add(0, 8'h10, 8'h10, 8'h00);
        add(0, 8'hC4, 8'h14, 8'h00);
        add(0, 8'hD4, 8'h15, 8'h00);
        add(0, 8'hBE, 8'h13, 8'h00);
        add(0, 8'h10, 8'h14, 8'h00);
        add(0, 8'h98, 8'h15, 8'h80);
        add(0, 8'hE0, 8'h80, 8'h80);
        add(0, 8'h4C, 8'h81, 8'h00);
        add(0, 8'h53, 8'h82, 8'h03);
        add(0, 8'h6F, 8'h83, 8'h0C);
        add(0, 8'hC4, 8'h84, 8'h0C);
        add(0, 8'hD4, 8'h88, 8'h0C);
        add(0, 8'hB0, 8'h88, 8'h0C);
        add(0, 8'h00, 8'h89, 8'h0C);
        add(0, 8'h1F, 8'h8A, 8'h0F);
        add(0, 8'h9F, 8'h8B, 8'hFF);
        add(0, 8'hE0, 8'hFF, 8'hFF);
        add(0, 8'h00, 8'h00, 8'hFF);
        add(0, 8'hB8, 8'hF8, 8'hFF);
        add(0, 8'h7C, 8'hF9, 8'hF0);
        add(1, 8'h2F, 8'h00, 8'h00);
        foreach (tbl[k]) begin
            step(tbl[k].clb, tbl[k].ins);
            check($sformatf("vec%0d pc", k), pc, tbl[k].pc);
            check($sformatf("vec%0d acc", k), accum_value, tbl[k].acc);
        end

        for (int k = 0; k < 7; k++) step(0, 8'h00);
        check("pre_halt pc", pc, 8'h07);
        step(0, 8'hF0);
        check("halt pc", pc, 8'h08);
        for (int k = 1; k <= 5; k++) begin
            step(0, 8'h15);
`ifdef CPU_CORE_HALT_EN
            check($sformatf("halted%0d pc", k), pc, 8'h08);
            check($sformatf("halted%0d acc", k), accum_value, 8'h00);
`else
            check($sformatf("nohalt%0d pc", k), pc, 8'(8 + k));
            check($sformatf("nohalt%0d acc", k), accum_value, 8'h05);
`endif
        end
        step(1, 8'h15);
        check("halt_reset pc", pc, 8'h00);
        check("halt_reset acc", accum_value, 8'h00);
        step(0, 8'h13);
        check("post_reset pc", pc, 8'h01);
        check("post_reset acc", accum_value, 8'h03);

        model(1, 8'h00);
        step(1, 8'h00);
        for (int k = 0; k < 400; k++) begin
            logic       c;
            logic [7:0] i;
            c = ($urandom_range(0, 31) == 0);
            i = 8'($urandom);
            model(c, i);
            step(c, i);
            check($sformatf("rand%0d pc", k), pc, 8'(m_pc));
            check($sformatf("rand%0d acc", k), accum_value, 8'(m_acc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
